reg_array_seq: RTL

- Sequencer for one register-array row datapath in the data router.
- Drives the array's 2-bit command (buffer load / shift / fifo load / hold) so it sweeps a KSIZE x KSIZE kernel window across a programmed number of output rows.
- Flags each cycle in which the array outputs hold a valid tap for the PE columns, and tags it with its (kx, ky) kernel coordinate.
- Handles buffer-data availability, PE back-pressure and start/done handshaking toward the layer controller.

---
 rtl/reg_array_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/reg_array_seq.sv
// Sequencer that sweeps a KSIZE x KSIZE kernel window over one register-array row datapath.
// Latency: command registered one cycle after its decision, tap valid the cycle after that.
// Backpressure: NE is issued and all counters hold while buffer data or PE readiness is missing.
module reg_array_seq #(
    parameter int KSIZE = 3,
    parameter int ROW_W = 8,
    parameter int KW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [ROW_W-1:0] i_num_rows,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_buf_valid,
    output logic             o_buf_rd,
    input  logic             i_pe_ready,
    output logic [1:0]       o_reg_array_cmd,
    output logic             o_pe_valid,
    output logic [KW-1:0]    o_kx,
    output logic [KW-1:0]    o_ky,
    output logic [ROW_W-1:0] o_row
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

    localparam logic [1:0]    CMD_IB = 2'b00;
    localparam logic [1:0]    CMD_SF = 2'b01;
    localparam logic [1:0]    CMD_IF = 2'b10;
    localparam logic [1:0]    CMD_NE = 2'b11;
    localparam logic [KW-1:0] K_LAST = KW'(KSIZE - 1);

    state_t           state, nxt_state;
    logic [KW-1:0]    kx, ky, nxt_kx, nxt_ky;
    logic [ROW_W-1:0] row, nxt_row, num_rows;
    logic [KW-1:0]    tap_kx, tap_ky, t_kx;
    logic [ROW_W-1:0] tap_row;
    logic [1:0]       nxt_cmd;
    logic             nxt_buf_rd, issue, end_kr, active, start_ok, start_zero;
    logic             cur_load;
    logic [KW-1:0]    cur_kx, cur_ky;
    logic [ROW_W-1:0] cur_row, cur_num;

    assign start_ok   = (state == IDLE) && i_start && (i_num_rows != '0);
    assign start_zero = (state == IDLE) && i_start && (i_num_rows == '0);

    // An accepted start evaluates the first load in the same cycle so the
    // first command reaches the array on the very next cycle.
    always_comb begin
        active     = start_ok || (state == LOAD) || (state == SHIFT);
        cur_load   = (state != SHIFT);
        cur_kx     = (state == IDLE) ? '0 : kx;
        cur_ky     = (state == IDLE) ? '0 : ky;
        cur_row    = (state == IDLE) ? '0 : row;
        cur_num    = (state == IDLE) ? i_num_rows : num_rows;
        nxt_state  = state;
        nxt_kx     = kx;
        nxt_ky     = ky;
        nxt_row    = row;
        nxt_cmd    = CMD_NE;
        nxt_buf_rd = 1'b0;
        issue      = 1'b0;
        end_kr     = 1'b0;
        t_kx       = cur_kx;
        if (active) begin
            nxt_state = cur_load ? LOAD : SHIFT;
            nxt_kx    = cur_kx;
            nxt_ky    = cur_ky;
            nxt_row   = cur_row;
            if (cur_load) begin
                if ((cur_ky == '0) ? (i_buf_valid && i_pe_ready) : i_pe_ready) begin
                    nxt_cmd    = (cur_ky == '0) ? CMD_IB : CMD_IF;
                    nxt_buf_rd = (cur_ky == '0);
                    issue      = 1'b1;
                    t_kx       = '0;
                    nxt_kx     = '0;
                    if (KSIZE > 1) nxt_state = SHIFT;
                    else           end_kr    = 1'b1;
                end
            end else if (i_pe_ready) begin
                nxt_cmd = CMD_SF;
                issue   = 1'b1;
                t_kx    = cur_kx + KW'(1);
                nxt_kx  = cur_kx + KW'(1);
                end_kr  = (cur_kx + KW'(1) == K_LAST);
            end
            if (end_kr) begin
                if (cur_ky != K_LAST) begin
                    nxt_ky    = cur_ky + KW'(1);
                    nxt_state = LOAD;
                end else begin
                    nxt_ky    = '0;
                    nxt_row   = cur_row + ROW_W'(1);
                    nxt_state = (cur_row == cur_num - ROW_W'(1)) ? FIN : LOAD;
                end
            end
        end else if (state == FIN) begin
            nxt_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            kx              <= '0;
            ky              <= '0;
            row             <= '0;
            num_rows        <= '0;
            tap_kx          <= '0;
            tap_ky          <= '0;
            tap_row         <= '0;
            o_reg_array_cmd <= CMD_NE;
            o_buf_rd        <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_pe_valid      <= 1'b0;
            o_kx            <= '0;
            o_ky            <= '0;
            o_row           <= '0;
        end else begin
            state           <= nxt_state;
            kx              <= nxt_kx;
            ky              <= nxt_ky;
            row             <= nxt_row;
            o_reg_array_cmd <= nxt_cmd;
            o_buf_rd        <= nxt_buf_rd;
            if (start_ok) num_rows <= i_num_rows;
            if (issue) begin
                tap_kx  <= t_kx;
                tap_ky  <= cur_ky;
                tap_row <= cur_row;
            end
            // A zero-row job completes immediately without ever raising busy.
            o_done <= (state == FIN) || start_zero;
            if (start_ok)           o_busy <= 1'b1;
            else if (state == FIN)  o_busy <= 1'b0;
            o_pe_valid <= (o_reg_array_cmd != CMD_NE);
            if (o_reg_array_cmd != CMD_NE) begin
                o_kx  <= tap_kx;
                o_ky  <= tap_ky;
                o_row <= tap_row;
            end
        end
    end
endmodule
